// File: rtl/axi_pack_pkg.sv
// Shared types and lane-index constants for the AXI pack converter R path.
package axi_pack_pkg;

    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DataWidth_I = 64;
    localparam int unsigned DataWidth_O = 512;
    localparam int unsigned IdWidth     = 4;

    localparam int unsigned NarrowBytes = DataWidth_I / 8;
    localparam int unsigned WideBytes   = DataWidth_O / 8;
    localparam int unsigned DataAlign_I = $clog2(NarrowBytes);
    localparam int unsigned DataAlign_O = $clog2(WideBytes);
    localparam int unsigned PtrWidth    = DataAlign_O + 1;
    localparam int unsigned StepWidth   = DataAlign_O + 2;

    typedef logic [7:0]             len_t;
    typedef logic [7:0]             stride_t;
    typedef logic [15:0]            nest_stride_t;
    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [2:0]             ax_size_t;
    typedef logic [DataAlign_I-1:0] nlane_t;
    typedef logic [DataAlign_O-1:0] wlane_t;
    typedef logic [PtrWidth-1:0]    ptr_t;
    typedef logic [StepWidth-1:0]   step_t;

    typedef struct packed {
        id_t                    id;
        logic [DataWidth_O-1:0] data;
        logic [1:0]             resp;
        logic                   last;
    } axi_r_wide_t;

    typedef struct packed {
        id_t                    id;
        logic [DataWidth_I-1:0] data;
        logic [1:0]             resp;
        logic                   last;
    } axi_r_narrow_t;

    typedef struct packed {
        id_t      id;
        ax_size_t ssr_size;
        stride_t  ssr_stride;
        addr_t    ssr_offset;
        logic     same_size;
        wlane_t   std_offset;
        logic     ssr_last;
        len_t     ssr_len;
    } sarq_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_pack_conv_r_pack_if.sv
// Bus bundle of the R packing stage: sarq head, wide R input, narrow R output.
interface axi_pack_conv_r_pack_if;
    import axi_pack_pkg::*;

    sarq_t         xsarq_out;
    logic          xsarq_empty;
    logic          xsarq_pop;
    logic          r_valid_i;
    logic          r_ready_o;
    axi_r_wide_t   r_chan_i;
    logic          r_valid_o;
    logic          r_ready_i;
    axi_r_narrow_t r_chan_o;

    modport slave (
        input  xsarq_out, xsarq_empty, r_valid_i, r_chan_i, r_ready_i,
        output xsarq_pop, r_ready_o, r_valid_o, r_chan_o
    );

    modport master (
        output xsarq_out, xsarq_empty, r_valid_i, r_chan_i, r_ready_i,
        input  xsarq_pop, r_ready_o, r_valid_o, r_chan_o
    );

endinterface

// File: rtl/axi_pack_conv_r_lane_extract.sv
// Picks a 2^size-byte element out of a wide beat and places it at a narrow lane.
module axi_pack_conv_r_lane_extract
    import axi_pack_pkg::*;
(
    input  logic [DataWidth_O-1:0] wide_data,
    input  wlane_t                 ptr,
    input  ax_size_t               size,
    input  nlane_t                 lane,
    output logic [DataWidth_I-1:0] narrow_data
);

    // Bytes falling past either bus edge are dropped rather than wrapped.
    always_comb begin
        narrow_data = '0;
        for (int b = 0; b < int'(NarrowBytes); b++) begin
            if (b >= int'(lane) && (b - int'(lane)) < (1 << size) &&
                (int'(ptr) + b - int'(lane)) < int'(WideBytes)) begin
                narrow_data[8*b +: 8] = wide_data[8*(int'(ptr) + b - int'(lane)) +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_pack_conv_r_pack.sv
// R packing stage: unpacks strided elements from wide beats into narrow beats.
// Optional output spill register enabled by defining AXI_PACK_CONV_R_SKID_EN.
//
// state  | meaning
// IDLE   | no sarq entry being served
// STREAM | serving the sarq head, one element per narrow handshake
module axi_pack_conv_r_pack
    import axi_pack_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_pack_conv_r_pack_if.slave bus,
    output logic                  err_o
);

    r_state_e state_q, state_d;
    len_t     elem_cnt_q, elem_cnt_d;
    ptr_t     ptr_q, ptr_d;
    logic     first_q, first_d;
    logic     err_q, err_d;

    sarq_t                  head;
    ptr_t                   ptr;
    step_t                  step, ptr_next;
    nlane_t                 lane;
    logic                   last_elem, wide_pop;
    logic                   core_valid, core_ready, hs;
    logic [DataWidth_I-1:0] elem_data;
    axi_r_narrow_t          core_chan;

    assign head      = bus.xsarq_out;
    assign ptr       = first_q ? {1'b0, head.std_offset} : ptr_q;
    assign step      = step_t'(step_t'(head.ssr_stride) + step_t'(1)) << head.ssr_size;
    assign ptr_next  = step_t'(ptr) + step;
    assign last_elem = (elem_cnt_q == head.ssr_len);
    assign wide_pop  = head.same_size | last_elem | (ptr_next >= step_t'(WideBytes));
    assign lane      = nlane_t'(head.ssr_offset[DataAlign_I-1:0] +
                                (nlane_t'(elem_cnt_q) << head.ssr_size));

    axi_pack_conv_r_lane_extract i_lane_extract (
        .wide_data   (bus.r_chan_i.data),
        .ptr         (ptr[DataAlign_O-1:0]),
        .size        (head.ssr_size),
        .lane        (lane),
        .narrow_data (elem_data)
    );

    assign core_valid    = (state_q == STREAM) & ~bus.xsarq_empty & bus.r_valid_i;
    assign hs            = core_valid & core_ready;
    assign bus.r_ready_o = hs & wide_pop;
    assign bus.xsarq_pop = hs & last_elem;
    assign err_o         = err_q;

    always_comb begin
        core_chan = '0;
        if (core_valid) begin
            core_chan.id   = head.id;
            core_chan.data = elem_data;
            core_chan.resp = bus.r_chan_i.resp;
            core_chan.last = head.ssr_last & last_elem;
        end
    end

    // Falling back to IDLE once the queue drains keeps back-to-back entries bubble-free.
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        ptr_d      = ptr_q;
        first_d    = first_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (!bus.xsarq_empty) state_d = STREAM;
            end
            STREAM: begin
                if (bus.xsarq_empty) state_d = IDLE;
                if (hs) begin
                    ptr_d = wide_pop ? ptr_t'(ptr_next[DataAlign_O-1:0]) : ptr_t'(ptr_next);
                    if (last_elem) begin
                        elem_cnt_d = '0;
                        first_d    = 1'b1;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                        first_d    = 1'b0;
                    end
                    if (wide_pop && ((bus.r_chan_i.last != last_elem) ||
                                     (bus.r_chan_i.id != head.id))) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            err_q      <= err_d;
        end
    end

`ifdef AXI_PACK_CONV_R_SKID_EN
    // Two-entry spill: A takes new beats, B parks A's beat when the consumer stalls.
    logic          a_full_q, b_full_q;
    axi_r_narrow_t a_data_q, b_data_q;
    logic          a_fill, a_drain, b_fill, b_drain;

    assign core_ready    = ~a_full_q | ~b_full_q;
    assign a_fill        = core_valid & core_ready;
    assign a_drain       = a_full_q & ~b_full_q;
    assign b_fill        = a_drain & ~bus.r_ready_i;
    assign b_drain       = b_full_q & bus.r_ready_i;
    assign bus.r_valid_o = a_full_q | b_full_q;
    assign bus.r_chan_o  = b_full_q ? b_data_q : a_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_fill) a_data_q <= core_chan;
            if (a_fill || a_drain) a_full_q <= a_fill;
            if (b_fill) b_data_q <= a_data_q;
            if (b_fill || b_drain) b_full_q <= b_fill;
        end
    end
`else
    assign core_ready    = bus.r_ready_i;
    assign bus.r_valid_o = core_valid;
    assign bus.r_chan_o  = core_chan;
`endif

endmodule

// File: tb/tb_axi_pack_conv_r_pack.sv
// Randomized bench for axi_pack_conv_r_pack against an absolute-position element model.
module tb_axi_pack_conv_r_pack;
    import axi_pack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic err;

    always #5 clk = ~clk;

    axi_pack_conv_r_pack_if bus();

    axi_pack_conv_r_pack dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .err_o (err)
    );

    typedef struct {
        logic [DataWidth_I-1:0] data;
        id_t                    id;
        logic [1:0]             resp;
        logic                   last;
        logic                   wpop;
        logic                   pop;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    sarq_t       sarq_q[$];
    axi_r_wide_t wq[$];
    bit          bad_q[$];
    exp_t        exp_q[$];
    int          g = 0;
    bit          err_exp = 1'b0;
    int          first_hs, last_hs;
    int          stall_elem = -1;
    int          stall_left = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic sarq_t mk(input int id, input int size, input int stride, input int len,
                                 input int same, input int std_off, input logic [31:0] soff,
                                 input int last);
        sarq_t e;
        e.id         = id_t'(id);
        e.ssr_size   = ax_size_t'(size);
        e.ssr_stride = stride_t'(stride);
        e.ssr_offset = soff;
        e.same_size  = same[0];
        e.std_offset = wlane_t'(std_off);
        e.ssr_last   = last[0];
        e.ssr_len    = len_t'(len);
        return e;
    endfunction

    // Element k sits at absolute byte std_offset + k*step of the entry's beat stream.
    task automatic add_entry(input sarq_t e, input bit bad);
        int step, nb, base, pos, bk, bk_next, byt, lane, nbytes, len;
        axi_r_wide_t w;
        exp_t x;
        len  = int'(e.ssr_len);
        step = (int'(e.ssr_stride) + 1) << e.ssr_size;
        nb   = e.same_size ? len + 1 : (int'(e.std_offset) + len * step) / 64 + 1;
        base = wq.size();
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < int'(DataWidth_O) / 32; i++) w.data[32*i +: 32] = $urandom;
            w.id   = e.id;
            w.resp = 2'($urandom_range(0, 3));
            w.last = (b == nb - 1) && !bad;
            wq.push_back(w);
            bad_q.push_back(bad && (b == nb - 1));
        end
        for (int k = 0; k <= len; k++) begin
            pos     = int'(e.std_offset) + k * step;
            bk      = e.same_size ? k : pos / 64;
            bk_next = e.same_size ? k + 1 : (pos + step) / 64;
            byt     = pos % 64;
            lane    = (int'(e.ssr_offset % 8) + (k << e.ssr_size)) % 8;
            nbytes  = 1 << e.ssr_size;
            x.data  = '0;
            for (int j = 0; j < nbytes; j++) begin
                if (lane + j < 8 && byt + j < 64)
                    x.data[8*(lane+j) +: 8] = wq[base+bk].data[8*(byt+j) +: 8];
            end
            x.id   = e.id;
            x.resp = wq[base+bk].resp;
            x.last = e.ssr_last && (k == len);
            x.pop  = (k == len);
            x.wpop = (k == len) || (bk_next != bk);
            exp_q.push_back(x);
        end
        sarq_q.push_back(e);
    endtask

    task automatic run(input int vprob, input int rprob, input int abort_after);
        int nhs = 0;
        for (int cyc = 0; cyc < 3000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            bus.xsarq_empty = (sarq_q.size() == 0);
            bus.xsarq_out   = (sarq_q.size() > 0) ? sarq_q[0] : '0;
            bus.r_valid_i   = (g < wq.size()) && (int'($urandom_range(0, 99)) < vprob);
            bus.r_chan_i    = (g < wq.size()) ? wq[g] : '0;
            bus.r_ready_i   = (int'($urandom_range(0, 99)) < rprob);
            if (nhs == stall_elem && stall_left > 0) begin
                bus.r_ready_i = 1'b0;
                stall_left--;
            end
            #1;
            check_val("err", 128'(err), 128'(err_exp));
            if (!bus.r_valid_i) check_val("vld_gate", 128'(bus.r_valid_o), 128'(0));
            if (bus.r_valid_o && exp_q.size() > 0) begin
                check_val("data", 128'(bus.r_chan_o.data), 128'(exp_q[0].data));
                check_val("id",   128'(bus.r_chan_o.id),   128'(exp_q[0].id));
                check_val("resp", 128'(bus.r_chan_o.resp), 128'(exp_q[0].resp));
                check_val("last", 128'(bus.r_chan_o.last), 128'(exp_q[0].last));
            end else if (bus.r_valid_o) begin
                check_val("spurious_vld", 128'(bus.r_valid_o), 128'(0));
            end
            if (bus.r_valid_o && bus.r_ready_i && exp_q.size() > 0) begin
                check_val("wide_rdy", 128'(bus.r_ready_o), 128'(exp_q[0].wpop));
                check_val("pop",      128'(bus.xsarq_pop), 128'(exp_q[0].pop));
                if (nhs == 0) first_hs = cyc;
                last_hs = cyc;
                void'(exp_q.pop_front());
                nhs++;
            end else begin
                check_val("rdy_idle", 128'(bus.r_ready_o), 128'(0));
                check_val("pop_idle", 128'(bus.xsarq_pop), 128'(0));
            end
            if (bus.r_valid_i && bus.r_ready_o && g < wq.size()) begin
                if (bad_q[g]) err_exp = 1'b1;
                g++;
            end
            if (bus.xsarq_pop && sarq_q.size() > 0) void'(sarq_q.pop_front());
            if (nhs == abort_after) break;
        end
        if (abort_after < 0) begin
            check_val("drained_r",    128'(exp_q.size()),  128'(0));
            check_val("drained_sarq", 128'(sarq_q.size()), 128'(0));
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.xsarq_out   = '0;
        bus.xsarq_empty = 1'b1;
        bus.r_valid_i   = 1'b0;
        bus.r_chan_i    = '0;
        bus.r_ready_i   = 1'b0;
        #1;
        check_val("rst_valid", 128'(bus.r_valid_o), 128'(0));
        check_val("rst_ready", 128'(bus.r_ready_o), 128'(0));
        check_val("rst_pop",   128'(bus.xsarq_pop), 128'(0));
        check_val("rst_chan",  128'(bus.r_chan_o),  128'(0));
        check_val("rst_err",   128'(err),           128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Direct pass-through: lanes 8,16,24,32 into narrow lane 0.
        add_entry(mk(1, 3, 0, 3, 1, 8, 32'h1008, 1), 1'b0);
        run(100, 100, -1);

        // Loop burst with a 3-cycle consumer stall at element 5.
        stall_elem = 5;
        stall_left = 3;
        add_entry(mk(2, 2, 1, 15, 0, 4, 32'h2000, 1), 1'b0);
        run(100, 100, -1);
        check_val("stall_used", 128'(stall_left), 128'(0));
        stall_elem = -1;

        // Back-to-back entries: no bubble across the entry boundary.
        add_entry(mk(3, 3, 0, 3, 0, 0, 32'h0, 0), 1'b0);
        add_entry(mk(4, 1, 2, 5, 0, 10, 32'h6, 1), 1'b0);
        run(100, 100, -1);
        check_val("b2b_span", 128'(last_hs - first_hs), 128'(9));

        // One-by-one entries; entry 2 carries a wrong wide last.
        for (int i = 0; i < 4; i++)
            add_entry(mk(5 + i, 2, 0, 0, 0, 20 * i, $urandom, 1), i == 1);
        run(100, 100, -1);
        check_val("err_sticky", 128'(err), 128'(1));

        // Asynchronous reset in the middle of an entry.
        add_entry(mk(9, 2, 1, 15, 0, 4, 32'h40, 1), 1'b0);
        run(100, 100, 3);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", 128'(bus.r_valid_o), 128'(0));
        check_val("mid_rst_ready", 128'(bus.r_ready_o), 128'(0));
        check_val("mid_rst_pop",   128'(bus.xsarq_pop), 128'(0));
        check_val("mid_rst_chan",  128'(bus.r_chan_o),  128'(0));
        check_val("mid_rst_err",   128'(err),           128'(0));
        sarq_q.delete();
        wq.delete();
        bad_q.delete();
        exp_q.delete();
        g               = 0;
        err_exp         = 1'b0;
        bus.xsarq_empty = 1'b1;
        bus.r_valid_i   = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Restart from a non-zero std_offset proves the entry starts fresh.
        add_entry(mk(10, 3, 0, 2, 0, 24, 32'h0, 1), 1'b0);
        run(100, 100, -1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                int sz;
                sz = int'($urandom_range(0, 3));
                add_entry(mk(int'($urandom_range(0, 15)), sz,
                             int'($urandom_range(0, (64 >> sz) - 1)),
                             int'($urandom_range(0, 20)), int'($urandom_range(0, 1)),
                             int'($urandom_range(0, 63)), $urandom,
                             int'($urandom_range(0, 1))), 1'b0);
            end
            run(70, 70, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
